ahb_sram_slave: RTL and testbench

Parametrised AHB-Lite single-port SRAM slave. Successor to the fixed 32-bit memory slave: configurable data width, depth and wait states, byte-lane writes via HSIZE, and an AHB ERROR response for illegal accesses. Sits behind the address decoder and read-data mux as a bus slave. Storage is a flop array.

---
 rtl/ahb_sram_slave.sv | 155 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave over a flop-array SRAM with configurable width, depth and wait states.
// Define AHB_SRAM_ERR_EN to give illegal transfers a two-cycle ERROR response; otherwise they wrap/align and complete OKAY.
module ahb_sram_slave #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);
    localparam int         NBYTES   = DATA_W / 8;
    localparam int         OFF_W    = $clog2(NBYTES);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(OFF_W);
    localparam logic [2:0] WAIT_LD  = 3'(WAIT_CYCLES);

`ifdef AHB_SRAM_ERR_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;
`endif

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]  a_idx;
    logic [NBYTES-1:0] a_be;
    logic              a_write;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept, slave_rdy, capture;
    logic              in_range, size_ok, align_ok;
    logic [OFF_W-1:0]  off;
    logic [NBYTES-1:0] be;

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign off     = HADDR[OFF_W-1:0];
    assign size_ok = (HSIZE <= MAX_SIZE);

    generate
        if (ADDR_W > OFF_W + IDX_W) begin : g_range
            assign in_range = ~|HADDR[ADDR_W-1:OFF_W+IDX_W];
        end else begin : g_no_range
            assign in_range = 1'b1;
        end
    endgenerate

    always_comb begin
        align_ok = 1'b1;
        for (int b = 0; b < OFF_W; b++) begin
            if ((3'(b) < HSIZE) && off[b]) align_ok = 1'b0;
        end
    end

    // A lane is enabled when it falls in the same 2^HSIZE block as the address offset.
    always_comb begin
        be = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (size_ok && align_ok)
                be[i] = ((OFF_W'(i) >> HSIZE) == (off >> HSIZE));
            else
`ifdef AHB_SRAM_ERR_EN
                be[i] = 1'b0;
`else
                be[i] = 1'b1;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        slave_rdy = 1'b0;
        capture   = 1'b0;
        case (state)
            S_WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = S_DATA;
            end
`ifdef AHB_SRAM_ERR_EN
            S_ERR1: state_nxt = S_ERR2;
`endif
            default: slave_rdy = 1'b1;
        endcase
        if (slave_rdy) begin
            state_nxt = S_IDLE;
            if (accept) begin
                capture = 1'b1;
`ifdef AHB_SRAM_ERR_EN
                if (!(in_range && size_ok && align_ok))
                    state_nxt = S_ERR1;
                else
`endif
                if (WAIT_CYCLES == 0)
                    state_nxt = S_DATA;
                else begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = WAIT_LD;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a_idx   <= '0;
            a_be    <= '0;
            a_write <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                a_idx   <= HADDR[OFF_W+IDX_W-1:OFF_W];
                a_be    <= be;
                a_write <= HWRITE;
            end
        end
    end

    // Storage is deliberately not reset; a reset during DATA drops the pending write.
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state == S_DATA) && a_write) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (a_be[i]) mem[a_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA = (state == S_DATA) ? mem[a_idx] : '0;

`ifdef AHB_SRAM_ERR_EN
    assign HREADYOUT = (state != S_WAIT) && (state != S_ERR1);
    assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
`else
    assign HREADYOUT = (state != S_WAIT);
    assign HRESP     = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, HBURST, HTRANS[0], in_range};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized bench for ahb_sram_slave: two instances (0 and 3 wait states) checked against a byte-array transaction model.
module tb_ahb_sram_slave;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 32;
    localparam int W0    = 0;
    localparam int W1    = 3;
`ifdef AHB_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk;
    logic        hreset    [2];
    logic        hsel      [2];
    logic        hwrite    [2];
    logic        hready    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] haddr     [2];
    logic [31:0] hwdata    [2];
    logic [31:0] hrdata    [2];
    logic [1:0]  htrans    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];

    logic [7:0]  mem_m [2][DEPTH*4];
    xfer_t       seq [$];
    int          n_chk, n_pass;
    logic [31:0] last_rdata;

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];

    ahb_sram_slave #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(W0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0]),
        .HREADY(hready[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb_sram_slave #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_CYCLES(W1)) u_dut1 (
        .HCLK(clk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HREADY(hready[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
        if (!ERR_EN) return 1'b1;
        return (a < 32'h400) && (s <= 3'd2) && ((a & ((32'd1 << s) - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [31:0] model_word(input int d, input int idx);
        return {mem_m[d][idx*4+3], mem_m[d][idx*4+2], mem_m[d][idx*4+1], mem_m[d][idx*4]};
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                               input logic [31:0] wd);
        int base, o, n;
        base = int'((a >> 2) % DEPTH) * 4;
        o    = int'(a % 4);
        n    = 1 << s;
        if (s <= 3'd2 && (o % n) == 0) begin
            for (int k = 0; k < n; k++) mem_m[d][base+o+k] = wd[8*(o+k) +: 8];
        end else begin
            for (int k = 0; k < 4; k++) mem_m[d][base+k] = wd[8*k +: 8];
        end
    endtask

    task automatic push(input bit wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        xfer_t x;
        x.wr = wr; x.addr = a; x.size = s; x.wdata = wd;
        seq.push_back(x);
    endtask

    task automatic bus_idle(input int d);
        hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
        haddr[d] = '0; hsize[d] = '0; hburst[d] = '0;
    endtask

    // Issues seq back-to-back as a pipelined master; entered and left at posedge+1 with the slave idle.
    task automatic run_seq(input int d);
        int ai, di, waits, cyc, exp_w;
        bit rdy, legal;
        logic [31:0] exp;
        ai = 0; di = -1; waits = 0; cyc = 0;
        exp_w = (d == 0) ? W0 : W1;
        while ((ai < seq.size() || di >= 0) && cyc < 4000) begin
            cyc++;
            if (ai < seq.size()) begin
                hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = seq[ai].addr;
                hwrite[d] = seq[ai].wr; hsize[d] = seq[ai].size;
                hburst[d] = 3'($urandom_range(0, 7));
            end else begin
                hsel[d] = 1'($urandom_range(0, 1)); htrans[d] = 2'b00; haddr[d] = $urandom;
            end
            hwdata[d] = (di >= 0) ? seq[di].wdata : $urandom;
            @(negedge clk);
            rdy = hreadyout[d];
            if (di >= 0) begin
                legal = is_legal(seq[di].addr, seq[di].size);
                if (!rdy) begin
                    waits++;
                    chk($sformatf("d%0d wait_resp", d), 32'(hresp[d]), legal ? 0 : 1);
                    chk($sformatf("d%0d wait_rdata", d), hrdata[d], 0);
                    if (waits > 16) begin
                        chk($sformatf("d%0d wait_timeout", d), waits, 16);
                        cyc = 4000;
                    end
                end else begin
                    chk($sformatf("d%0d nwait", d), waits, legal ? exp_w : 1);
                    chk($sformatf("d%0d resp", d), 32'(hresp[d]), legal ? 0 : 1);
                    if (!seq[di].wr) begin
                        exp = legal ? model_word(d, int'((seq[di].addr >> 2) % DEPTH)) : 32'd0;
                        chk($sformatf("d%0d rdata@%08h", d, seq[di].addr), hrdata[d], exp);
                        last_rdata = hrdata[d];
                    end else if (legal) begin
                        model_write(d, seq[di].addr, seq[di].size, seq[di].wdata);
                    end
                end
            end
            @(posedge clk); #1;
            if (rdy) begin
                di = -1;
                if (ai < seq.size()) begin
                    di = ai; ai++; waits = 0;
                end
            end
        end
        if (cyc >= 4000) chk($sformatf("d%0d seq_timeout", d), cyc, 0);
        bus_idle(d);
        seq.delete();
    endtask

    task automatic gen_random(input int n);
        int r, o;
        logic [31:0] a;
        logic [2:0]  s;
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      a = $urandom_range(0, 15) << 2;
            else if (r < 88) a = $urandom_range(0, DEPTH-1) << 2;
            else if (r < 94) a = 32'h400 + ($urandom_range(0, 255) << 2);
            else             a = $urandom & ~32'h3;
            if ($urandom_range(0, 4) == 0) begin
                s = 3'($urandom_range(0, 3));
                a = a | $urandom_range(0, 3);
            end else begin
                s = 3'($urandom_range(0, 2));
                o = $urandom_range(0, 3) & ~((1 << s) - 1);
                a = a | o;
            end
            push(1'($urandom_range(0, 1)), a, s, $urandom);
        end
    endtask

    initial begin
        logic [31:0] old;
        n_chk = 0; n_pass = 0; last_rdata = '0;
        for (int d = 0; d < 2; d++) begin
            hreset[d] = 1'b1; hwdata[d] = '0;
            bus_idle(d);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst_ready", d), 32'(hreadyout[d]), 1);
            chk($sformatf("d%0d rst_resp", d), 32'(hresp[d]), 0);
            chk($sformatf("d%0d rst_rdata", d), hrdata[d], 0);
            hreset[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d idle_ready", d), 32'(hreadyout[d]), 1);
            chk($sformatf("d%0d idle_rdata", d), hrdata[d], 0);
        end
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) push(1'b1, 32'(i * 4), 3'd2, $urandom);
            run_seq(d);
        end

        for (int d = 0; d < 2; d++) begin
            push(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
            push(1'b0, 32'h10, 3'd2, 32'h0);
            run_seq(d);
            chk($sformatf("d%0d raw_word", d), last_rdata, 32'hDEADBEEF);

            push(1'b1, 32'h20, 3'd2, 32'h0);
            push(1'b1, 32'h22, 3'd0, 32'h00AB0000);
            push(1'b0, 32'h20, 3'd2, 32'h0);
            run_seq(d);
            chk($sformatf("d%0d byte_lane", d), last_rdata, 32'h00AB0000);

            old = model_word(d, 0);
            push(1'b0, 32'h400, 3'd2, 32'h0);
            run_seq(d);
            chk($sformatf("d%0d oob_read", d), last_rdata, ERR_EN ? 32'h0 : old);

            push(1'b1, 32'h1, 3'd1, 32'hCAFEF00D);
            push(1'b0, 32'h0, 3'd2, 32'h0);
            run_seq(d);
            chk($sformatf("d%0d unaligned_hw", d), last_rdata, ERR_EN ? old : 32'hCAFEF00D);
        end

        // Deselected NONSEQ must be ignored.
        hsel[0] = 1'b0; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = 32'h40; hsize[0] = 3'd2;
        old = model_word(0, 16);
        @(posedge clk); #1;
        bus_idle(0); hwdata[0] = ~old;
        @(negedge clk);
        chk("d0 hsel0_ready", 32'(hreadyout[0]), 1);
        @(posedge clk); #1;
        push(1'b0, 32'h40, 3'd2, 32'h0);
        run_seq(0);
        chk("d0 hsel0_nowrite", last_rdata, old);

        // Reset in the second wait cycle of a write on the 3-wait instance.
        old = model_word(1, 12);
        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h30; hsize[1] = 3'd2;
        @(posedge clk); #1;
        bus_idle(1); hwdata[1] = 32'h11111111;
        @(posedge clk); #1;
        hreset[1] = 1'b1;
        @(negedge clk);
        chk("d1 midwait_ready", 32'(hreadyout[1]), 0);
        @(posedge clk); #1;
        hreset[1] = 1'b0;
        @(negedge clk);
        chk("d1 abort_ready", 32'(hreadyout[1]), 1);
        chk("d1 abort_resp", 32'(hresp[1]), 0);
        chk("d1 abort_rdata", hrdata[1], 0);
        @(posedge clk); #1;
        push(1'b0, 32'h30, 3'd2, 32'h0);
        run_seq(1);
        chk("d1 abort_nowrite", last_rdata, old);

        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 40; b++) begin
                gen_random($urandom_range(1, 6));
                run_seq(d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
